// File: rtl/addsub_pkg.sv
// Shared types for the adder/subtractor result buffer: op encoding, the
// per-entry layout {s, cout, op, zero, neg} and the drop-counter width.
package addsub_pkg;

  localparam int DATA_W     = 32;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0] s;
    logic              cout;
    op_t               op;
    logic              zero;
    logic              neg;
  } buf_entry_t;

  localparam int ENTRY_W = $bits(buf_entry_t);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/addsub_buf_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous
// read port. The read port feeds the first-word-fall-through head directly.
module addsub_buf_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write the addressed entry on a push.
  // NOTE: storage has no reset; validity is tracked by the level counter, so
  // stale contents are never observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/addsub_result_buf.sv
// Capture FIFO behind the registered adder/subtractor. Results are queued
// with their op select and leave over a valid/ready handshake; results that
// arrive while full (and not popping) are dropped and counted, never stalled.
// Optional build macro: ADDSUB_BUF_FLAGS_EN stores zero/neg flags per entry;
// without it out_zero/out_neg are tied low and entries are N+2 bits wide.
// N must equal addsub_pkg::DATA_W, which fixes the entry layout.
module addsub_result_buf
  import addsub_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [N-1:0]            in_s,
  input  logic                    in_cout,
  input  logic                    in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_s,
  output logic                    out_cout,
  output logic                    out_op,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic [$clog2(DEPTH):0]  level,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
`ifdef ADDSUB_BUF_FLAGS_EN
  localparam int MEM_W = ENTRY_W;
`else
  localparam int MEM_W = N + 2;
`endif

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic [MEM_W-1:0]      w_wr_word;
  logic [MEM_W-1:0]      w_rd_word;

  // Full/empty come from the level counter, so pointers need no extra wrap bit.
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = in_valid && ((r_level != FULL_LVL) || w_pop);
  assign w_drop    = in_valid && !w_push;

`ifdef ADDSUB_BUF_FLAGS_EN
  buf_entry_t w_wr_entry;
  buf_entry_t w_rd_entry;

  // Assemble the stored entry; flags are captured from in_s at push time.
  always_comb begin
    // NOTE: default every field first so no path leaves a bit unassigned (no latch).
    w_wr_entry      = '0;
    w_wr_entry.s    = in_s;
    w_wr_entry.cout = in_cout;
    w_wr_entry.op   = op_t'(in_op);
    w_wr_entry.zero = (in_s == '0);
    w_wr_entry.neg  = in_s[N-1];
  end

  assign w_wr_word  = w_wr_entry;
  assign w_rd_entry = buf_entry_t'(w_rd_word);
  assign out_s      = w_rd_entry.s;
  assign out_cout   = w_rd_entry.cout;
  assign out_op     = w_rd_entry.op;
  assign out_zero   = w_rd_entry.zero;
  assign out_neg    = w_rd_entry.neg;
`else
  assign w_wr_word  = {in_s, in_cout, in_op};
  assign out_s      = w_rd_word[MEM_W-1:2];
  assign out_cout   = w_rd_word[1];
  assign out_op     = w_rd_word[0];
  assign out_zero   = 1'b0;
  assign out_neg    = 1'b0;
`endif

  addsub_buf_mem #(
    .DEPTH (DEPTH),
    .W     (MEM_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_word),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_word)
  );

  // Advance pointers on push/pop and track occupancy; both at once holds level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Count results lost to a full buffer, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign level    = r_level;
  assign drop_cnt = r_drop_cnt;

endmodule
